// File: rtl/fetch_unit_if.sv
// Fetch-stage bus between the control FSM / datapath (master) and fetch_unit (slave).
// Carries the strobes and branch inputs in, and the PC/IR state with decoded fields out.
interface fetch_unit_if;
    logic        ir_we;
    logic        pc_we;
    logic        jump;
    logic        beq;
    logic        bne;
    logic        zero;
    logic [31:0] rs_data;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_sext;
    logic [31:0] instr_count;
    logic        align_err;

    modport master (
        output ir_we, pc_we, jump, beq, bne, zero, rs_data, imem_data,
        input  pc, pc_plus4, instr, opcode, funct, rs, rt, rd, imm_sext,
               instr_count, align_err
    );

    modport slave (
        input  ir_we, pc_we, jump, beq, bne, zero, rs_data, imem_data,
        output pc, pc_plus4, instr, opcode, funct, rs, rt, rd, imm_sext,
               instr_count, align_err
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch / next-PC stage: holds PC, IR and fetch-time PC+4, decodes IR fields,
// and applies at most one redirect (branch, J/JAL, JR) per fetched instruction.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    fetch_unit_if.slave bus
);
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic [31:0] r_instr;
    logic [31:0] r_instr_count;
    logic        r_redirect_done;
    logic        r_align_err;

    logic [5:0]  w_opcode;
    logic [31:0] w_imm_sext;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_target;
    logic        w_take;
    logic        w_is_jr;
    logic        w_misaligned;
    logic        w_redirect;

    assign w_opcode   = r_instr[31:26];
    assign w_imm_sext = {{16{r_instr[15]}}, r_instr[15:0]};

    assign w_take          = bus.jump | (bus.beq & bus.zero) | (bus.bne & ~bus.zero);
    assign w_is_jr         = bus.jump && (w_opcode == 6'd0);
    assign w_branch_target = r_pc_plus4 + {w_imm_sext[29:0], 2'b00};
    assign w_jump_target   = {r_pc_plus4[31:28], r_instr[25:0], 2'b00};
    assign w_misaligned    = w_is_jr && (bus.rs_data[1:0] != 2'b00);

    // A fetch in the same cycle suppresses the redirect; only the first taken redirect counts.
    assign w_redirect = bus.pc_we & ~bus.ir_we & ~r_redirect_done & w_take;

    always_comb begin
        w_target = w_branch_target;
        if (w_is_jr) begin
            w_target = {bus.rs_data[31:2], 2'b00};
        end else if (bus.jump) begin
            w_target = w_jump_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc            <= RESET_PC;
            r_pc_plus4      <= RESET_PC + 32'd4;
            r_instr         <= 32'd0;
            r_redirect_done <= 1'b1;
            r_instr_count   <= 32'd0;
            r_align_err     <= 1'b0;
        end else if (bus.ir_we) begin
            r_instr         <= bus.imem_data;
            r_pc_plus4      <= r_pc + 32'd4;
            r_pc            <= r_pc + 32'd4;
            r_redirect_done <= 1'b0;
            r_instr_count   <= r_instr_count + 32'd1;
        end else if (w_redirect) begin
            r_pc            <= w_target;
            r_redirect_done <= 1'b1;
            if (w_misaligned) begin
                r_align_err <= 1'b1;
            end
        end
    end

    assign bus.pc          = r_pc;
    assign bus.pc_plus4    = r_pc_plus4;
    assign bus.instr       = r_instr;
    assign bus.opcode      = w_opcode;
    assign bus.funct       = r_instr[5:0];
    assign bus.rs          = r_instr[25:21];
    assign bus.rt          = r_instr[20:16];
    assign bus.rd          = r_instr[15:11];
    assign bus.imm_sext    = w_imm_sext;
    assign bus.instr_count = r_instr_count;
    assign bus.align_err   = r_align_err;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a spec-level model checked every cycle, plus literal pins.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference state kept in architectural terms.
    bit          m_ok = 1'b0;
    logic [31:0] m_pc, m_pc4, m_instr, m_cnt;
    bit          m_done, m_err;

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 32'h0; m_pc4 = 32'h4; m_instr = 32'h0;
            m_cnt = 0; m_done = 1'b1; m_err = 1'b0; m_ok = 1'b1;
        end else if (m_ok && bus.ir_we) begin
            m_instr = bus.imem_data;
            m_pc4   = m_pc + 4;
            m_pc    = m_pc + 4;
            m_done  = 1'b0;
            m_cnt   = m_cnt + 1;
        end else if (m_ok && bus.pc_we && !m_done) begin
            int unsigned op;
            int          imm;
            op  = m_instr >> 26;
            imm = int'($signed(m_instr[15:0]));
            if (bus.jump) begin
                if (op == 0) begin
                    m_pc = bus.rs_data - (bus.rs_data % 4);
                    if (bus.rs_data % 4 != 0) m_err = 1'b1;
                end else begin
                    m_pc = (m_pc4 & 32'hF000_0000) + ((m_instr & 32'h03FF_FFFF) * 4);
                end
                m_done = 1'b1;
            end else if ((bus.beq && bus.zero) || (bus.bne && !bus.zero)) begin
                m_pc   = m_pc4 + imm * 4;
                m_done = 1'b1;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_ok) begin
            cmp("pc",          bus.pc,          m_pc);
            cmp("pc_plus4",    bus.pc_plus4,    m_pc4);
            cmp("instr",       bus.instr,       m_instr);
            cmp("opcode",      32'(bus.opcode), m_instr >> 26);
            cmp("funct",       32'(bus.funct),  m_instr % 64);
            cmp("rs",          32'(bus.rs),     (m_instr >> 21) % 32);
            cmp("rt",          32'(bus.rt),     (m_instr >> 16) % 32);
            cmp("rd",          32'(bus.rd),     (m_instr >> 11) % 32);
            cmp("imm_sext",    bus.imm_sext,    32'(int'($signed(m_instr[15:0]))));
            cmp("instr_count", bus.instr_count, m_cnt);
            cmp("align_err",   32'(bus.align_err), 32'(m_err));
        end
    end

    task automatic step(input logic iw, input logic pw, input logic j, input logic bq,
                        input logic bn, input logic z, input logic [31:0] rsd,
                        input logic [31:0] imd);
        bus.ir_we = iw; bus.pc_we = pw; bus.jump = j; bus.beq = bq; bus.bne = bn;
        bus.zero = z; bus.rs_data = rsd; bus.imem_data = imd;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] imd);
        step(1, 0, 0, 0, 0, 0, 32'h0, imd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        reset = 1'b0;
        cmp("rst_pc", bus.pc, 32'h0);
        cmp("rst_cnt", bus.instr_count, 32'h0);
        cmp("rst_pc4", bus.pc_plus4, 32'h4);
        cmp("rst_err", 32'(bus.align_err), 32'h0);

        // Sequential fetch
        fetch(32'h2008_0005);
        cmp("addi_instr", bus.instr, 32'h2008_0005);
        cmp("addi_op", 32'(bus.opcode), 32'h08);
        cmp("addi_pc", bus.pc, 32'h4);
        cmp("addi_pc4", bus.pc_plus4, 32'h4);
        cmp("addi_cnt", bus.instr_count, 32'h1);
        cmp("addi_imm", bus.imm_sext, 32'h5);
        fetch(32'h0000_0000);
        cmp("nop_pc", bus.pc, 32'h8);

        // Taken BEQ at pc=8, imm -2, three PCReg pulses
        fetch(32'h1022_FFFE);
        cmp("beq_pc4", bus.pc_plus4, 32'hC);
        cmp("beq_imm", bus.imm_sext, 32'hFFFF_FFFE);
        step(0, 1, 0, 1, 0, 1, 32'h0, 32'h0);
        cmp("beq_pc1", bus.pc, 32'h4);
        step(0, 1, 0, 1, 0, 1, 32'h0, 32'h0);
        step(0, 1, 0, 1, 0, 1, 32'h0, 32'h0);
        cmp("beq_pc3", bus.pc, 32'h4);

        // BNE: not taken first, then taken since no redirect happened yet
        fetch(32'h1422_0010);
        step(0, 1, 0, 0, 1, 1, 32'h0, 32'h0);
        cmp("bne_nt_pc", bus.pc, 32'h8);
        step(0, 1, 0, 0, 1, 0, 32'h0, 32'h0);
        cmp("bne_t_pc", bus.pc, 32'h48);
        fetch(32'h0000_0000);
        cmp("after_bne_pc", bus.pc, 32'h4C);

        // JR to 0x1000_0010, then J and JAL
        fetch(32'h03E0_0008);
        step(0, 1, 1, 0, 0, 0, 32'h1000_0010, 32'h0);
        cmp("jr_pc", bus.pc, 32'h1000_0010);
        fetch(32'h0800_0040);
        step(0, 1, 1, 0, 0, 0, 32'h0, 32'h0);
        cmp("j_pc", bus.pc, 32'h1000_0100);
        cmp("j_pc4", bus.pc_plus4, 32'h1000_0014);
        step(0, 1, 1, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        cmp("j_pc4_wb", bus.pc_plus4, 32'h1000_0014);
        cmp("j_pc_hold", bus.pc, 32'h1000_0100);
        fetch(32'h0C00_0040);
        step(0, 1, 1, 1, 0, 1, 32'h0, 32'h0);
        cmp("jal_prio_pc", bus.pc, 32'h1000_0100);
        cmp("jal_pc4", bus.pc_plus4, 32'h1000_0104);

        // Misaligned JR
        fetch(32'h03E0_0008);
        step(0, 1, 1, 0, 0, 0, 32'h0000_0203, 32'h0);
        cmp("jrm_pc", bus.pc, 32'h0000_0200);
        cmp("jrm_err", 32'(bus.align_err), 32'h1);
        fetch(32'h0000_0000);
        cmp("jrm_err_sticky", 32'(bus.align_err), 32'h1);
        cmp("jrm_next_pc", bus.pc, 32'h0000_0204);

        // Fetch wins over a simultaneous redirect
        step(1, 1, 1, 0, 0, 0, 32'h0, 32'h0800_0040);
        cmp("prio_pc", bus.pc, 32'h0000_0208);
        cmp("prio_instr", bus.instr, 32'h0800_0040);
        cmp("prio_cnt", bus.instr_count, 32'd11);

        // Reset together with a fetch, pending redirect discarded
        reset = 1'b1;
        step(1, 0, 0, 0, 0, 0, 32'h0, 32'hDEAD_BEEF);
        reset = 1'b0;
        cmp("rst2_pc", bus.pc, 32'h0);
        cmp("rst2_instr", bus.instr, 32'h0);
        cmp("rst2_cnt", bus.instr_count, 32'h0);
        cmp("rst2_err", 32'(bus.align_err), 32'h0);
        step(0, 1, 1, 0, 0, 0, 32'h0000_0100, 32'h0);
        cmp("rst2_noredir", bus.pc, 32'h0);
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and next-PC stage of the multicycle CPU, sitting directly upstream of the control FSM. It holds the program counter, the instruction register and the captured PC+4. It decodes instruction fields for the FSM and datapath, and applies sequential, branch, jump and jump-register PC updates. Updates are gated by the FSM's PC-write and IR-write strobes, so the PC changes at most once per fetch and at most once per redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ir_we  in  1  instruction-register write strobe (FSM instrReg)
- pc_we  in  1  PC redirect strobe (FSM PCReg)
- jump  in  1  unconditional jump request (J, JAL, JR)
- beq  in  1  branch-if-equal request
- bne  in  1  branch-if-not-equal request
- zero  in  1  ALU zero flag from the rs−rt compare
- rs_data  in  32  register-file rs value (JR target)
- imem_data  in  32  instruction memory read data for address pc
- pc  out  32  current PC; also the instruction memory address
- pc_plus4  out  32  PC+4 captured at fetch (JAL link value, branch base)
- instr  out  32  instruction register
- opcode  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- rs, rt, rd  out  5 each  instr[25:21], instr[20:16], instr[15:11]
- imm_sext  out  32  sign-extended instr[15:0]
- instr_count  out  32  number of fetches since reset
- align_err  out  1  sticky; set on a misaligned JR target

## Operation
- Registered state: pc, pc_plus4, instr, redirect_done, instr_count, align_err. All field outputs decode combinationally from instr.
- **Fetch** (ir_we=1):
  - instr <= imem_data; pc_plus4 <= pc+4; pc <= pc+4.
  - redirect_done <= 0; instr_count <= instr_count+1, wrapping at 2^32.
- **Redirect** (pc_we=1, ir_we=0, redirect_done=0), evaluated against the current instr:
  - take = jump | (beq & zero) | (bne & ~zero).
  - If take:
    - JR (opcode 0): target = rs_data.
    - J/JAL: target = {pc_plus4[31:28], instr[25:0], 2'b00}.
    - beq/bne: target = pc_plus4 + (imm_sext << 2), mod 2^32.
    - pc <= target; redirect_done <= 1.
  - If not taken: pc holds; redirect_done unchanged.
- JR target with rs_data[1:0] != 0: pc <= {rs_data[31:2], 2'b00}; align_err <= 1. align_err clears only on reset.
- pc_we with redirect_done=1: ignored. This covers repeated PCReg pulses in EX/MEM/WB, which must not move pc.
- ir_we and pc_we in the same cycle: the fetch has priority and the redirect is dropped. The FSM must present a redirect in a cycle before the next ir_we.
- More than one of jump/beq/bne asserted: jump has priority, then beq, then bne.
- Reset:
  - pc=RESET_PC; pc_plus4=RESET_PC+4.
  - instr=0, so opcode=0 and funct=0.
  - redirect_done=1 (no redirect before the first fetch); instr_count=0; align_err=0.

## Timing
- Every state update occurs on the rising clk edge. reset dominates all strobes in the same cycle.
- imem_data is sampled in the ir_we cycle, so it must be valid for the pc in that cycle. Fetch latency is one edge from ir_we to instr valid.
- Redirect latency is one edge: the new pc is visible the cycle after the pc_we edge and is used by the next ir_we.
- The decoded fields (opcode, funct, rs, rt, rd, imm_sext) change only on the edge after ir_we. They are stable for the whole ID/EX/MEM/WB sequence.
- pc_plus4 holds its fetch-time value until the next fetch, so JAL sees the correct link value in WB.
- Reset mid-instruction discards the pending redirect and the current instr. The next fetch is from RESET_PC.

## Test plan
- **Reset, sequential fetch:** reset, then ir_we with imem_data=32'h2008_0005 (addi)
  - After reset: pc=0, instr_count=0.
  - After ir_we: instr=32'h2008_0005, opcode=6'h08, pc=4, pc_plus4=4, instr_count=1, imm_sext=5.
- **Taken branch, single update:** fetch BEQ at pc=8 with imm=16'hFFFE, zero=1, then pc_we for three separate cycles
  - pc becomes 8+4−8=4 after the first pc_we.
  - pc stays 4 through the remaining pulses.
- **Not-taken BNE:** zero=1, pc_we → pc stays at pc_plus4 (e.g. 12); the next fetch reads address 12.
- **J and JAL:** fetch at pc=32'h1000_0010 with instr[25:0]=26'h00_0040, then jump+pc_we
  - pc=32'h1000_0100.
  - pc_plus4=32'h1000_0014 is held through WB.
- **JR misaligned:** rs_data=32'h0000_0203, jump+pc_we with opcode 0 → pc=32'h0000_0200, align_err=1; align_err stays 1 until reset.
- **Priority and reset:**
  - ir_we and pc_we together with jump=1 → the fetch wins and pc=pc+4.
  - Reset asserted together with ir_we → pc=RESET_PC, instr=0, instr_count=0.
